// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : lsu_pkg
// Brief   : Shared types and request checks for the LSU memory controller.
// Revision: 1.0
// ============================================================================
package lsu_pkg;

    localparam int unsigned LSU_DW = 32;

    typedef enum logic [1:0] {
        SIZE_B = 2'b00,
        SIZE_H = 2'b01,
        SIZE_W = 2'b10
    } mem_size_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WRITE  = 2'd2,
        RESP   = 2'd3
    } lsu_state_e;

    // True for a misaligned half/word or the reserved size encoding.
    function automatic logic lsu_bad_req(input logic [1:0] size, input logic [1:0] lane);
        logic bad;
        case (size)
            SIZE_B:  bad = 1'b0;
            SIZE_H:  bad = lane[0];
            SIZE_W:  bad = (lane != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module  : lsu_align
// Brief   : Load lane extract/extend and store lane merge for a 32-bit word.
// Revision: 1.0
// ============================================================================
module lsu_align
    import lsu_pkg::*;
#(
    parameter int unsigned DW = LSU_DW
) (
    input  logic [DW-1:0] word_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [1:0]    lane_i,
    input  logic [1:0]    size_i,
    input  logic          unsigned_i,
    output logic [DW-1:0] load_o,
    output logic [DW-1:0] merge_o
);

    logic [7:0]    w_byte;
    logic [15:0]   w_half;
    logic [4:0]    w_bsh;
    logic [4:0]    w_hsh;
    logic [DW-1:0] w_mask;
    logic [DW-1:0] w_ins;

    always_comb begin
        w_bsh  = {lane_i, 3'b000};
        w_hsh  = {lane_i[1], 4'b0000};
        w_byte = word_i[w_bsh +: 8];
        w_half = lane_i[1] ? word_i[31:16] : word_i[15:0];

        case (size_i)
            SIZE_B:  load_o = {{(DW-8){w_byte[7] & ~unsigned_i}}, w_byte};
            SIZE_H:  load_o = {{(DW-16){w_half[15] & ~unsigned_i}}, w_half};
            default: load_o = word_i;
        endcase

        w_mask = '0;
        w_ins  = '0;
        case (size_i)
            SIZE_B: begin
                w_mask = DW'(8'hFF) << w_bsh;
                w_ins  = DW'(wdata_i[7:0]) << w_bsh;
            end
            SIZE_H: begin
                w_mask = DW'(16'hFFFF) << w_hsh;
                w_ins  = DW'(wdata_i[15:0]) << w_hsh;
            end
            default: begin
                w_mask = '1;
                w_ins  = wdata_i;
            end
        endcase
        merge_o = (word_i & ~w_mask) | w_ins;
    end

endmodule
`default_nettype wire

// File: rtl/lsu_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : lsu_mem_ctrl
// Brief   : Single-outstanding load/store initiator for a word-wide data memory.
// Revision: 1.0
// ============================================================================
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned DATA_ADDR_WIDTH = 32,
    parameter int unsigned DATA_WORD_WIDTH = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       req_valid_i,
    output logic                       req_ready_o,
    input  logic                       req_we_i,
    input  logic [1:0]                 req_size_i,
    input  logic                       req_unsigned_i,
    input  logic [DATA_ADDR_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WORD_WIDTH-1:0] req_wdata_i,
    output logic                       rsp_valid_o,
    output logic [DATA_WORD_WIDTH-1:0] rsp_rdata_o,
    output logic                       rsp_err_o,
    output logic                       mem_en_o,
    output logic                       mem_we_o,
    output logic [DATA_ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WORD_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WORD_WIDTH-1:0] mem_rdata_i
);

    localparam int unsigned AW = DATA_ADDR_WIDTH;
    localparam int unsigned DW = DATA_WORD_WIDTH;

    lsu_state_e    state_q, state_d;
    logic          we_q, we_d;
    logic [1:0]    size_q, size_d;
    logic          uns_q, uns_d;
    logic          bad_q, bad_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] merged_q, merged_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          err_q, err_d;

    logic [DW-1:0] w_load;
    logic [DW-1:0] w_merge;
    logic          w_rmw;

    lsu_align #(.DW(DW)) u_align (
        .word_i     (mem_rdata_i),
        .wdata_i    (wdata_q),
        .lane_i     (addr_q[1:0]),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .load_o     (w_load),
        .merge_o    (w_merge)
    );

    assign rsp_valid_o = (state_q == RESP);
    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        size_d      = size_q;
        uns_d       = uns_q;
        bad_d       = bad_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        merged_d    = merged_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        req_ready_o = 1'b0;
        mem_en_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        w_rmw       = we_q && (size_q != SIZE_W);

        case (state_q)
            IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    we_d    = req_we_i;
                    size_d  = req_size_i;
                    uns_d   = req_unsigned_i;
                    addr_d  = req_addr_i;
                    wdata_d = req_wdata_i;
                    bad_d   = lsu_bad_req(req_size_i, req_addr_i[1:0]);
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                // Rejected requests pass through here with the port quiet so
                // their response lands at the same latency as a load.
                if (bad_q) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    mem_en_o   = 1'b1;
                    mem_addr_o = {addr_q[AW-1:2], 2'b00};
                    if (w_rmw) begin
                        merged_d = w_merge;
                        state_d  = WRITE;
                    end else begin
                        mem_we_o    = we_q;
                        mem_wdata_o = we_q ? wdata_q : '0;
                        rdata_d     = we_q ? '0 : w_load;
                        err_d       = 1'b0;
                        state_d     = RESP;
                    end
                end
            end
            WRITE: begin
                mem_en_o    = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = {addr_q[AW-1:2], 2'b00};
                mem_wdata_o = merged_q;
                rdata_d     = '0;
                err_d       = 1'b0;
                state_d     = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Keep the port quiet while reset is held so an interrupted RMW never commits.
        if (rst_i) begin
            mem_en_o    = 1'b0;
            mem_we_o    = 1'b0;
            mem_addr_o  = '0;
            mem_wdata_o = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            size_q   <= 2'b00;
            uns_q    <= 1'b0;
            bad_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            merged_q <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            size_q   <= size_d;
            uns_q    <= uns_d;
            bad_q    <= bad_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            merged_q <= merged_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

endmodule
`default_nettype wire
